// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU control path: opcode fields and
// the multicycle controller state encoding.
package cpu_ctrl_pkg;

   // instruction[3:1] class codes
   localparam logic [2:0] OP_LDA = 3'b000;
   localparam logic [2:0] OP_STA = 3'b001;
   localparam logic [2:0] OP_ADA = 3'b010;
   localparam logic [2:0] OP_ANA = 3'b011;
   localparam logic [2:0] OP_JMP = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;

   // full 4-bit register-register codes
   localparam logic [3:0] OP_MVR = 4'b1100;
   localparam logic [3:0] OP_ADR = 4'b1101;
   localparam logic [3:0] OP_ANR = 4'b1110;
   localparam logic [3:0] OP_ORR = 4'b1111;

   typedef enum logic [3:0] {
      IF     = 4'd0,
      DEC    = 4'd1,
      LDI    = 4'd2,
      MVR    = 4'd3,
      RT     = 4'd4,
      RT_WB  = 4'd5,
      IF2    = 4'd6,
      MEM_RD = 4'd7,
      MEM_WR = 4'd8,
      JMP    = 4'd9,
      WB     = 4'd10
   } ctrl_state_t;

   function automatic logic is_mem_state(input ctrl_state_t s);
      return s inside {IF, IF2, MEM_RD, MEM_WR};
   endfunction

endpackage

// File: rtl/wait_counter.sv
// Per-state wait counter: clears on state entry, counts up while enabled and
// flags the final cycle of the stretched state.
module wait_counter #(
   parameter int CNT_W = 1,
   parameter int LAST  = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (clr)
         cnt_q <= '0;
      else if (en && !last)
         cnt_q <= cnt_q + 1'b1;
   end

   assign last = (cnt_q == LAST_V);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 4-bit-opcode accumulator datapath; drives all
// load strobes and mux selects from the current state and wait counter.
module multicycle_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] instruction,
   input  logic       out_jump_sel,
   input  logic       stall,
   output logic       ld_PC,
   output logic       cen_PC,
   output logic       ld_IR,
   output logic       ld_DI,
   output logic       ld_ALU,
   output logic       write_en_rf,
   output logic       ld_CZN,
   output logic       ld_TR,
   output logic       sel_IR_3_2,
   output logic       sel_DI_4_3,
   output logic       sel_RF_write_src_TR_12_5,
   output logic       sel_RF_write_src_ALU,
   output logic       sel_RF_write_src_reg1,
   output logic       sel_MEM_src_TR,
   output logic       sel_MEM_src_PC,
   output logic       sel_ALU_src_reg1,
   output logic       sel_ALU_src_TR,
   output logic       sel_CZN_src_RF,
   output logic       sel_CZN_src_ALU,
   output logic       sel_PC_src_jump,
   output logic       MEM_read,
   output logic       MEM_write,
   output logic [3:0] state,
   output logic       instr_done
);

   localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   ctrl_state_t state_q, state_n;
   logic        last, mem_st, final_cyc, stalled, cnt_clr;

   assign mem_st    = is_mem_state(state_q);
   assign final_cyc = !mem_st || last;
   assign stalled   = (state_q == IF) && stall;
   // Any state change (or a stall in IF) restarts the wait count for the next state.
   assign cnt_clr   = (state_n != state_q) || stalled;

   wait_counter #(
      .CNT_W (CNT_W),
      .LAST  (WAIT_CYCLES)
   ) u_wait_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (mem_st),
      .last (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IF;
      else
         state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IF:      if (!stall && last) state_n = DEC;
         DEC: begin
            if (instruction[3:1] == OP_LDI)
               state_n = LDI;
            else if (instruction == OP_MVR)
               state_n = MVR;
            else if (instruction inside {OP_ADR, OP_ANR, OP_ORR})
               state_n = RT;
            else
               state_n = IF2;
         end
         RT:      state_n = RT_WB;
         IF2: begin
            if (last) begin
               if (instruction[3:1] == OP_STA)
                  state_n = MEM_WR;
               else if (instruction[3:1] == OP_JMP)
                  state_n = JMP;
               else
                  state_n = MEM_RD;
            end
         end
         MEM_RD:  if (last) state_n = WB;
         MEM_WR:  if (last) state_n = IF;
         LDI, MVR, RT_WB, JMP, WB: state_n = IF;
         default: state_n = IF;
      endcase
   end

   always_comb begin
      ld_PC                    = 1'b0;
      cen_PC                   = 1'b0;
      ld_IR                    = 1'b0;
      ld_DI                    = 1'b0;
      ld_ALU                   = 1'b0;
      write_en_rf              = 1'b0;
      ld_CZN                   = 1'b0;
      ld_TR                    = 1'b0;
      sel_IR_3_2               = 1'b0;
      sel_DI_4_3               = 1'b0;
      sel_RF_write_src_TR_12_5 = 1'b0;
      sel_RF_write_src_ALU     = 1'b0;
      sel_RF_write_src_reg1    = 1'b0;
      sel_MEM_src_TR           = 1'b0;
      sel_MEM_src_PC           = 1'b0;
      sel_ALU_src_reg1         = 1'b0;
      sel_ALU_src_TR           = 1'b0;
      sel_CZN_src_RF           = 1'b0;
      sel_CZN_src_ALU          = 1'b0;
      sel_PC_src_jump          = 1'b0;
      MEM_read                 = 1'b0;
      MEM_write                = 1'b0;
      instr_done               = 1'b0;
      // Reset masks everything combinationally so an abort is seen at once.
      if (!rst) begin
         unique case (state_q)
            IF: if (!stall) begin
               MEM_read       = 1'b1;
               sel_MEM_src_PC = 1'b1;
               ld_IR          = last;
               ld_PC          = last;
            end
            LDI: begin
               ld_DI      = 1'b1;
               instr_done = 1'b1;
            end
            MVR: begin
               sel_IR_3_2            = 1'b1;
               sel_RF_write_src_reg1 = 1'b1;
               write_en_rf           = 1'b1;
               ld_CZN                = 1'b1;
               sel_CZN_src_ALU       = 1'b1;
               instr_done            = 1'b1;
            end
            RT: begin
               sel_IR_3_2       = 1'b1;
               sel_ALU_src_reg1 = 1'b1;
               ld_ALU           = 1'b1;
               ld_CZN           = 1'b1;
               sel_CZN_src_ALU  = 1'b1;
            end
            RT_WB: begin
               sel_RF_write_src_ALU = 1'b1;
               write_en_rf          = 1'b1;
               instr_done           = 1'b1;
            end
            IF2: begin
               MEM_read       = 1'b1;
               sel_MEM_src_PC = 1'b1;
               ld_TR          = last;
               ld_PC          = last;
            end
            MEM_RD: begin
               MEM_read       = 1'b1;
               sel_MEM_src_TR = 1'b1;
               if (last) begin
                  if (instruction[3:1] == OP_LDA) begin
                     ld_DI = 1'b1;
                  end else begin
                     sel_ALU_src_TR  = 1'b1;
                     ld_ALU          = 1'b1;
                     ld_CZN          = 1'b1;
                     sel_CZN_src_ALU = 1'b1;
                  end
               end
            end
            WB: begin
               write_en_rf = 1'b1;
               if (instruction[3:1] == OP_LDA)
                  sel_DI_4_3 = 1'b1;
               else
                  sel_RF_write_src_ALU = 1'b1;
               instr_done = 1'b1;
            end
            MEM_WR: begin
               MEM_write      = 1'b1;
               sel_MEM_src_TR = 1'b1;
               instr_done     = final_cyc;
            end
            JMP: begin
               ld_PC           = out_jump_sel;
               sel_PC_src_jump = out_jump_sel;
               instr_done      = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (WAIT_CYCLES 0 and 2) checked
// cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;
   import cpu_ctrl_pkg::*;

   localparam int B_LD_PC = 0,  B_CEN_PC = 1,  B_LD_IR = 2,  B_LD_DI = 3;
   localparam int B_LD_ALU = 4, B_WE_RF = 5,   B_LD_CZN = 6, B_LD_TR = 7;
   localparam int B_S_IR32 = 8, B_S_DI43 = 9,  B_S_RF_TR = 10, B_S_RF_ALU = 11;
   localparam int B_S_RF_R1 = 12, B_S_MEM_TR = 13, B_S_MEM_PC = 14, B_S_ALU_R1 = 15;
   localparam int B_S_ALU_TR = 16, B_S_CZN_RF = 17, B_S_CZN_ALU = 18, B_S_PC_J = 19;
   localparam int B_MRD = 20, B_MWR = 21, B_DONE = 22;

   logic        clk;
   logic        rst_v   [2];
   logic [3:0]  instr_v [2];
   logic        js_v    [2];
   logic        stall_v [2];
   logic [22:0] o0, o2;
   logic [3:0]  st0, st2;
   logic [26:0] obs [2];

   logic [26:0] exp_q [$];
   int n_tests = 0;
   int n_fail  = 0;

   assign obs[0] = {st0, o0};
   assign obs[1] = {st2, o2};

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   multicycle_controller #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst_v[0]), .instruction(instr_v[0]),
      .out_jump_sel(js_v[0]), .stall(stall_v[0]),
      .ld_PC(o0[B_LD_PC]), .cen_PC(o0[B_CEN_PC]), .ld_IR(o0[B_LD_IR]),
      .ld_DI(o0[B_LD_DI]), .ld_ALU(o0[B_LD_ALU]), .write_en_rf(o0[B_WE_RF]),
      .ld_CZN(o0[B_LD_CZN]), .ld_TR(o0[B_LD_TR]), .sel_IR_3_2(o0[B_S_IR32]),
      .sel_DI_4_3(o0[B_S_DI43]), .sel_RF_write_src_TR_12_5(o0[B_S_RF_TR]),
      .sel_RF_write_src_ALU(o0[B_S_RF_ALU]), .sel_RF_write_src_reg1(o0[B_S_RF_R1]),
      .sel_MEM_src_TR(o0[B_S_MEM_TR]), .sel_MEM_src_PC(o0[B_S_MEM_PC]),
      .sel_ALU_src_reg1(o0[B_S_ALU_R1]), .sel_ALU_src_TR(o0[B_S_ALU_TR]),
      .sel_CZN_src_RF(o0[B_S_CZN_RF]), .sel_CZN_src_ALU(o0[B_S_CZN_ALU]),
      .sel_PC_src_jump(o0[B_S_PC_J]), .MEM_read(o0[B_MRD]), .MEM_write(o0[B_MWR]),
      .state(st0), .instr_done(o0[B_DONE])
   );

   multicycle_controller #(.WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst_v[1]), .instruction(instr_v[1]),
      .out_jump_sel(js_v[1]), .stall(stall_v[1]),
      .ld_PC(o2[B_LD_PC]), .cen_PC(o2[B_CEN_PC]), .ld_IR(o2[B_LD_IR]),
      .ld_DI(o2[B_LD_DI]), .ld_ALU(o2[B_LD_ALU]), .write_en_rf(o2[B_WE_RF]),
      .ld_CZN(o2[B_LD_CZN]), .ld_TR(o2[B_LD_TR]), .sel_IR_3_2(o2[B_S_IR32]),
      .sel_DI_4_3(o2[B_S_DI43]), .sel_RF_write_src_TR_12_5(o2[B_S_RF_TR]),
      .sel_RF_write_src_ALU(o2[B_S_RF_ALU]), .sel_RF_write_src_reg1(o2[B_S_RF_R1]),
      .sel_MEM_src_TR(o2[B_S_MEM_TR]), .sel_MEM_src_PC(o2[B_S_MEM_PC]),
      .sel_ALU_src_reg1(o2[B_S_ALU_R1]), .sel_ALU_src_TR(o2[B_S_ALU_TR]),
      .sel_CZN_src_RF(o2[B_S_CZN_RF]), .sel_CZN_src_ALU(o2[B_S_CZN_ALU]),
      .sel_PC_src_jump(o2[B_S_PC_J]), .MEM_read(o2[B_MRD]), .MEM_write(o2[B_MWR]),
      .state(st2), .instr_done(o2[B_DONE])
   );

   task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference model: one expected {state, outputs} word per cycle
   task automatic emit(input ctrl_state_t s, input logic [22:0] o);
      exp_q.push_back({s, o});
   endtask

   task automatic mem_phase(input ctrl_state_t s, input logic [22:0] base,
                            input logic [22:0] fin, input int w, input bit done_last);
      for (int c = 0; c <= w; c++) begin
         logic [22:0] o;
         o = base;
         if (c == w) begin
            o = o | fin;
            if (done_last) o[B_DONE] = 1'b1;
         end
         emit(s, o);
      end
   endtask

   task automatic build_exp(input int op, input bit js, input int stall_n, input int w);
      logic [22:0] b, f;
      int grp;
      grp = op / 2;
      for (int i = 0; i < stall_n; i++) emit(IF, '0);
      b = '0; b[B_MRD] = 1; b[B_S_MEM_PC] = 1;
      f = '0; f[B_LD_IR] = 1; f[B_LD_PC] = 1;
      mem_phase(IF, b, f, w, 1'b0);
      emit(DEC, '0);
      if (grp == 5) begin
         b = '0; b[B_LD_DI] = 1; b[B_DONE] = 1;
         emit(LDI, b);
      end else if (op == 12) begin
         b = '0; b[B_S_IR32] = 1; b[B_S_RF_R1] = 1; b[B_WE_RF] = 1;
         b[B_LD_CZN] = 1; b[B_S_CZN_ALU] = 1; b[B_DONE] = 1;
         emit(MVR, b);
      end else if (op >= 13) begin
         b = '0; b[B_S_IR32] = 1; b[B_S_ALU_R1] = 1; b[B_LD_ALU] = 1;
         b[B_LD_CZN] = 1; b[B_S_CZN_ALU] = 1;
         emit(RT, b);
         b = '0; b[B_S_RF_ALU] = 1; b[B_WE_RF] = 1; b[B_DONE] = 1;
         emit(RT_WB, b);
      end else begin
         b = '0; b[B_MRD] = 1; b[B_S_MEM_PC] = 1;
         f = '0; f[B_LD_TR] = 1; f[B_LD_PC] = 1;
         mem_phase(IF2, b, f, w, 1'b0);
         if (grp == 1) begin
            b = '0; b[B_MWR] = 1; b[B_S_MEM_TR] = 1;
            mem_phase(MEM_WR, b, '0, w, 1'b1);
         end else if (grp == 4) begin
            b = '0; b[B_DONE] = 1;
            if (js) begin b[B_LD_PC] = 1; b[B_S_PC_J] = 1; end
            emit(JMP, b);
         end else begin
            b = '0; b[B_MRD] = 1; b[B_S_MEM_TR] = 1;
            f = '0;
            if (grp == 0) f[B_LD_DI] = 1;
            else begin f[B_S_ALU_TR] = 1; f[B_LD_ALU] = 1; f[B_LD_CZN] = 1; f[B_S_CZN_ALU] = 1; end
            mem_phase(MEM_RD, b, f, w, 1'b0);
            b = '0; b[B_WE_RF] = 1; b[B_DONE] = 1;
            if (grp == 0) b[B_S_DI43] = 1; else b[B_S_RF_ALU] = 1;
            emit(WB, b);
         end
      end
   endtask

   function automatic int exp_latency(input int op, input int w, input int stall_n);
      int grp;
      grp = op / 2;
      if (grp == 5 || op == 12) return 3 + w + stall_n;
      if (op >= 13)             return 4 + w + stall_n;
      if (grp == 1)             return 4 + 3 * w + stall_n;
      if (grp == 4)             return 4 + 2 * w + stall_n;
      return 5 + 3 * w + stall_n;
   endfunction

   // driver: called just after a posedge with the DUT at the start of IF
   task automatic run_instr(input int d, input int w, input int op, input bit js, input int stall_n);
      int cyc, done_cyc;
      build_exp(op, js, stall_n, w);
      instr_v[d] = 4'(op);
      js_v[d]    = js;
      cyc        = 0;
      done_cyc   = -1;
      while (exp_q.size() > 0) begin
         logic [26:0] e;
         stall_v[d] = (cyc < stall_n);
         @(negedge clk);
         cyc++;
         e = exp_q.pop_front();
         check($sformatf("d%0d op%0h cyc%0d", d, op, cyc), obs[d], e);
         if (obs[d][B_DONE] && done_cyc < 0) done_cyc = cyc;
         @(posedge clk);
         #1;
      end
      stall_v[d] = 1'b0;
      check($sformatf("latency d%0d op%0h", d, op), 27'(done_cyc), 27'(exp_latency(op, w, stall_n)));
   endtask

   task automatic run_abort(input int d, input int w, input int op, input int n_before);
      build_exp(op, 1'b0, 0, w);
      instr_v[d] = 4'(op);
      for (int i = 0; i < n_before; i++) begin
         logic [26:0] e;
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("abort d%0d cyc%0d", d, i + 1), obs[d], e);
         @(posedge clk);
         #1;
      end
      rst_v[d] = 1'b1;
      #1;
      check($sformatf("abort_now d%0d", d), obs[d], {IF, 23'd0});
      exp_q.delete();
      @(negedge clk);
      check($sformatf("abort_hold d%0d", d), obs[d], {IF, 23'd0});
      @(posedge clk);
      #1;
      rst_v[d] = 1'b0;
   endtask

   task automatic run_suite(input int d, input int w);
      run_instr(d, w, 4'b1101, 1'b0, 0);   // ADR
      run_instr(d, w, 4'b0000, 1'b0, 0);   // LDA
      run_instr(d, w, 4'b1000, 1'b0, 0);   // JMP not taken
      run_instr(d, w, 4'b1001, 1'b1, 0);   // JMP taken
      run_instr(d, w, 4'b0010, 1'b0, 0);   // STA
      run_instr(d, w, 4'b1010, 1'b0, 5);   // LDI after a 5-cycle stall
      run_instr(d, w, 4'b1100, 1'b0, 0);   // MVR
      run_instr(d, w, 4'b0101, 1'b0, 0);   // ADA
      run_instr(d, w, 4'b0111, 1'b0, 0);   // ANA
      // reset lands in the first MEM_RD cycle of ADA
      run_abort(d, w, 4'b0100, 2 * (w + 1) + 1);
      run_instr(d, w, 4'b0100, 1'b0, 0);
      for (int i = 0; i < 40; i++) begin
         int sn;
         sn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_instr(d, w, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), sn);
      end
   endtask

   initial begin
      rst_v   = '{1'b1, 1'b1};
      instr_v = '{4'd0, 4'd0};
      js_v    = '{1'b0, 1'b0};
      stall_v = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset w0", obs[0], {IF, 23'd0});
         check("reset w2", obs[1], {IF, 23'd0});
      end
      @(posedge clk);
      #1;
      rst_v[0] = 1'b0;
      run_suite(0, 0);
      rst_v[0] = 1'b1;
      rst_v[1] = 1'b0;
      run_suite(1, 2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle control FSM for the 4-bit-opcode accumulator datapath. It sequences fetch, decode, operand fetch, memory access, ALU and writeback for every instruction class, including LDA, STA, ADA, ANA and JMP. It stretches every memory-access state by a configurable number of wait cycles and supports a fetch stall. It sits between the instruction register and the datapath select/load lines and drives them purely from its state.

## Interface
- WAIT_CYCLES, 0: extra cycles each memory-access state is held (0..15).
- CNT_W, $clog2(WAIT_CYCLES+1) clamped to ≥1: wait-counter width (derived; do not override).
- clk  in  1  clock; all state updates occur on its rising edge.
- rst  in  1  reset, asynchronous and active-high; forces state IF.
- instruction  in  4  IR[3:0] opcode field.
- out_jump_sel  in  1  jump condition from the flag logic; 1 = take jump.
- stall  in  1  hold in IF; no strobes issued.
- ld_PC, cen_PC, ld_IR, ld_DI, ld_ALU, write_en_rf, ld_CZN, ld_TR  out  1 each  register load/enable strobes.
- sel_IR_3_2, sel_DI_4_3, sel_RF_write_src_TR_12_5, sel_RF_write_src_ALU, sel_RF_write_src_reg1, sel_MEM_src_TR, sel_MEM_src_PC, sel_ALU_src_reg1, sel_ALU_src_TR, sel_CZN_src_RF, sel_CZN_src_ALU, sel_PC_src_jump  out  1 each  mux selects.
- MEM_read, MEM_write  out  1 each  memory command.
- state  out  4  current state encoding (debug).
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

## Operation
- Opcode map:
  - instruction[3:1]: LDA=000, STA=001, ADA=010, ANA=011, JMP=100, LDI=101.
  - Full 4-bit R-type codes: MVR=1100, ADR=1101, ANR=1110, ORR=1111.
  - All 16 codes are legal.
- States and transitions:
  - IF → DEC.
  - DEC → LDI | MVR | RT | IF2, selected by opcode.
  - LDI → IF.
  - MVR → IF.
  - RT → RT_WB → IF.
  - IF2 → MEM_RD for LDA/ADA/ANA, MEM_WR for STA, JMP for JMP.
  - MEM_RD → WB.
  - MEM_WR → IF.
  - JMP → IF.
  - WB → IF.
- Outputs are default 0 and depend only on state, wait counter, opcode and out_jump_sel:
  - IF: MEM_read, sel_MEM_src_PC; final cycle adds ld_IR and ld_PC.
  - LDI: ld_DI.
  - MVR: sel_IR_3_2, sel_RF_write_src_reg1, write_en_rf, ld_CZN, sel_CZN_src_ALU.
  - RT: sel_IR_3_2, sel_ALU_src_reg1, ld_ALU, ld_CZN, sel_CZN_src_ALU.
  - RT_WB: sel_RF_write_src_ALU, write_en_rf.
  - IF2: MEM_read, sel_MEM_src_PC; final cycle adds ld_TR and ld_PC.
  - MEM_RD: MEM_read, sel_MEM_src_TR; final cycle adds:
    - for LDA: ld_DI;
    - for ADA/ANA: sel_ALU_src_TR, ld_ALU, ld_CZN, sel_CZN_src_ALU.
  - WB:
    - LDA: write_en_rf, sel_DI_4_3;
    - ADA/ANA: write_en_rf, sel_RF_write_src_ALU.
  - MEM_WR: MEM_write, sel_MEM_src_TR.
  - JMP: if out_jump_sel, ld_PC and sel_PC_src_jump; otherwise no strobe.
- Wait states:
  - Memory states are IF, IF2, MEM_RD and MEM_WR.
  - Each memory state lasts WAIT_CYCLES+1 cycles, tracked by a counter that clears on state entry.
  - MEM_read/MEM_write stay asserted for every cycle of the state.
  - Load strobes fire only on the final cycle.
- Stall:
  - Sampled in IF only; while stall=1 the FSM stays in IF with all outputs 0 and the counter held at 0.
  - Stall is ignored in every other state.
- instr_done is high on the final cycle of LDI, MVR, RT_WB, WB, MEM_WR and JMP.

## Timing
- Reset:
  - rst high: state=IF, counter=0.
  - Every strobe, select and instr_done is 0 while rst is high.
  - The first fetch strobe appears in the cycle after rst deasserts.
- Latency with WAIT_CYCLES=0 (cycles, IF through done):
  - LDI 3, MVR 3.
  - ADR/ANR/ORR 4.
  - LDA 5, ADA/ANA 5.
  - STA 4, JMP 4.
- Latency with WAIT_CYCLES=W: add W per memory state visited.
- The opcode must be stable from DEC until instr_done.
- out_jump_sel is sampled combinationally in the JMP cycle.
- rst asserted mid-instruction aborts it immediately; no further strobes are issued.

## Structure
- Shared package cpu_ctrl_pkg holds the opcode localparams and the typedef enum logic [3:0] ctrl_state_t (IF, DEC, LDI, MVR, RT, RT_WB, IF2, MEM_RD, MEM_WR, JMP, WB).
- One sub-module, wait_counter: a CNT_W-bit counter with clear-on-entry and a `last` flag.

## Test plan
- rst high for 2 cycles, then ADR (1101), WAIT_CYCLES=0 → states IF,DEC,RT,RT_WB; ld_ALU in cycle 3, write_en_rf in cycle 4, instr_done in cycle 4.
- LDA (0000), WAIT_CYCLES=2 → IF and IF2 each 3 cycles with MEM_read; ld_DI on MEM_RD cycle 3; instr_done 11 cycles after IF entry.
- JMP (1000) with out_jump_sel=0 → no ld_PC in JMP; with out_jump_sel=1 → ld_PC=1 and sel_PC_src_jump=1 for one cycle.
- STA (0010) → MEM_write=1 with sel_MEM_src_TR in cycle 4, no RF write; instr_done in cycle 4.
- stall=1 for 5 cycles in IF → no ld_IR/ld_PC during the stall; fetch completes the cycle after stall drops.
- rst pulsed during MEM_RD of ADA → all strobes 0 immediately, state=IF, no WB cycle occurs.
